// File: rtl/tri_rr_sched_pkg.sv
// Shared types for the tri_rr_sched round-robin scheduler.
//   state_e : scheduler FSM state encoding (IDLE=0, BUSY=1)
package tri_rr_sched_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/tri_rr_pick.sv
// Combinational rotating-priority picker.
// Scans the request vector starting at i_ptr and wrapping upward; the first set bit wins.
//   i_req    : level requests, bit i = requester i
//   i_ptr    : highest-priority requester index for this pick
//   o_onehot : one-hot winner (zero when nothing requests)
//   o_id     : encoded winner index (0 when nothing requests)
//   o_any    : at least one request present
module tri_rr_pick #(
  parameter int unsigned REQ_N    = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [REQ_N-1:0]    i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [REQ_N-1:0]    o_onehot,
  output logic [ID_WIDTH-1:0] o_id,
  output logic                o_any
);

  always_comb begin
    int unsigned w_idx;
    w_idx    = 0;
    o_onehot = '0;
    o_id     = '0;
    o_any    = 1'b0;
    for (int unsigned k = 0; k < REQ_N; k++) begin
      w_idx = (int'(i_ptr) + k) % REQ_N;
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_onehot[w_idx] = 1'b1;
        o_id            = ID_WIDTH'(w_idx);
      end
    end
  end

endmodule

// File: rtl/tri_rr_sched.sv
// Round-robin scheduler that shares one multi-cycle datapath resource among REQ_N requesters.
// Grants one requester at a time, pulses o_rsc_start on the first grant cycle and holds the
// grant until i_rsc_done; a busy-cycle watchdog forces release and sets a sticky error.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_enable         : allow new grants
//   i_req            : level requests, bit i = requester i
//   o_gnt            : registered one-hot grant
//   o_gnt_vld        : any grant active
//   o_gnt_id         : encoded granted index (0 when idle)
//   o_rsc_start      : one-cycle pulse on the first cycle of each grant
//   i_rsc_done       : resource completion, only looked at while busy
//   o_timeout_err    : sticky forced-release flag
//   i_err_clr        : clears o_timeout_err (a simultaneous timeout wins)
module tri_rr_sched
  import tri_rr_sched_pkg::*;
#(
  parameter int unsigned REQ_N     = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned HOLD_MAX  = 15,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [REQ_N-1:0]    i_req,
  output logic [REQ_N-1:0]    o_gnt,
  output logic                o_gnt_vld,
  output logic [ID_WIDTH-1:0] o_gnt_id,
  output logic                o_rsc_start,
  input  logic                i_rsc_done,
  output logic                o_timeout_err,
  input  logic                i_err_clr
);

  state_e                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_WIDTH-1:0]  r_busy_cnt, w_busy_cnt_nxt;
  logic [REQ_N-1:0]      r_gnt, w_gnt_nxt;
  logic [ID_WIDTH-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic                  r_gnt_vld, w_gnt_vld_nxt;
  logic                  r_start, w_start_nxt;
  logic                  r_err, w_err_nxt;

  logic [REQ_N-1:0]      w_pick_onehot;
  logic [ID_WIDTH-1:0]   w_pick_id;
  logic                  w_pick_any;
  logic                  w_grant, w_release, w_timeout, w_cnt_hit;

  tri_rr_pick #(
    .REQ_N    (REQ_N),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_id     (w_pick_id),
    .o_any    (w_pick_any)
  );

  assign w_cnt_hit = (r_busy_cnt == CNT_WIDTH'(HOLD_MAX));
  assign w_grant   = (r_state == StIdle) && i_enable && w_pick_any;
  // Done on the HOLD_MAX cycle is a normal release, so done masks the timeout.
  assign w_release = (r_state == StBusy) && (i_rsc_done || w_cnt_hit);
  assign w_timeout = (r_state == StBusy) && !i_rsc_done && w_cnt_hit;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_grant)   w_state_nxt = StBusy;
      StBusy:  if (w_release) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output / datapath next values; every output is registered below.
  always_comb begin
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_start_nxt    = w_grant;
    w_busy_cnt_nxt = r_busy_cnt;
    w_ptr_nxt      = r_ptr;
    w_err_nxt      = r_err;

    if (w_grant) begin
      w_gnt_nxt      = w_pick_onehot;
      w_gnt_id_nxt   = w_pick_id;
      w_gnt_vld_nxt  = 1'b1;
      w_busy_cnt_nxt = '0;
    end else if (w_release) begin
      w_gnt_nxt     = '0;
      w_gnt_id_nxt  = '0;
      w_gnt_vld_nxt = 1'b0;
      w_ptr_nxt     = (r_gnt_id == ID_WIDTH'(REQ_N - 1)) ? '0 : r_gnt_id + ID_WIDTH'(1);
    end else if (r_state == StBusy && r_busy_cnt != '1) begin
      w_busy_cnt_nxt = r_busy_cnt + CNT_WIDTH'(1);
    end

    if (w_timeout) begin
      w_err_nxt = 1'b1;
    end else if (i_err_clr) begin
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_start    <= 1'b0;
      r_busy_cnt <= '0;
      r_ptr      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_start    <= w_start_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_gnt_id      = r_gnt_id;
  assign o_gnt_vld     = r_gnt_vld;
  assign o_rsc_start   = r_start;
  assign o_timeout_err = r_err;

endmodule

// File: tb/tb_tri_rr_sched.sv
// Self-checking bench for tri_rr_sched: a transaction-level reference model predicts each
// cycle's outputs and each grant; a negedge monitor pops and compares against the DUT.
module tb_tri_rr_sched;

  localparam int N    = 4;
  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       rsc_start;
  logic       rsc_done;
  logic       timeout_err;
  logic       err_clr;

  always #5 clk = ~clk;

  tri_rr_sched #(
    .REQ_N     (N),
    .ID_WIDTH  (2),
    .HOLD_MAX  (HOLD),
    .CNT_WIDTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_req         (req),
    .o_gnt         (gnt),
    .o_gnt_vld     (gnt_vld),
    .o_gnt_id      (gnt_id),
    .o_rsc_start   (rsc_start),
    .i_rsc_done    (rsc_done),
    .o_timeout_err (timeout_err),
    .i_err_clr     (err_clr)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       start;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   gq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one operation in flight, owner, how long it has run, rotation pointer.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;
  bit m_start;
  bit m_err;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_start = 0; m_err = 0;
  endfunction

  function automatic void model_update(input bit en, input logic [3:0] rq, input bit dn,
                                       input bit clr);
    bit to;
    to = 0;
    if (!m_busy) begin
      m_start = 0;
      if (en && rq != 4'd0) begin
        for (int k = 0; k < N; k++) begin
          if (!m_busy && rq[(m_ptr + k) % N]) begin
            m_busy  = 1;
            m_owner = (m_ptr + k) % N;
          end
        end
        m_cnt   = 0;
        m_start = 1;
        gq.push_back(m_owner);
      end
    end else begin
      m_start = 0;
      if (dn || m_cnt == HOLD) begin
        to     = !dn;
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        m_cnt++;
      end
    end
    if (to) m_err = 1;
    else if (clr) m_err = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = m_busy ? 4'(1 << m_owner) : 4'd0;
    e.vld   = m_busy;
    e.id    = m_busy ? 2'(m_owner) : 2'd0;
    e.start = m_start;
    e.err   = m_err;
    return e;
  endfunction

  task automatic step(input bit en, input logic [3:0] rq, input bit dn, input bit clr);
    enable   = en;
    req      = rq;
    rsc_done = dn;
    err_clr  = clr;
    @(posedge clk);
    model_update(en, rq, dn, clr);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic finish_op();
    for (int c = 0; c < 40 && m_busy; c++) step(0, 4'd0, 1, 0);
  endtask

  // Monitor: per-cycle state compare, plus grant-order scoreboard on each start pulse.
  always @(negedge clk) begin
    exp_t e;
    int   w;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_vld, gnt_id, rsc_start, timeout_err} !== e) begin
        errors++;
        $display("FAIL cycle_state t=%0t: got gnt=%b vld=%b id=%0d start=%b err=%b want gnt=%b vld=%b id=%0d start=%b err=%b",
                 $time, gnt, gnt_vld, gnt_id, rsc_start, timeout_err,
                 e.gnt, e.vld, e.id, e.start, e.err);
      end
    end
    if (rsc_start === 1'b1) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_event: got start for id=%0d want no grant", gnt_id);
      end else begin
        w = gq.pop_front();
        if (gnt_id !== 2'(w)) begin
          errors++;
          $display("FAIL grant_event: got id=%0d want id=%0d", gnt_id, w);
        end
      end
    end
  end

  int ord[5] = '{0, 1, 2, 3, 0};
  int n;
  int hold;

  initial begin
    rst_n = 1'b0; enable = 0; req = '0; rsc_done = 0; err_clr = 0;
    model_reset();
    #1;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_vld", int'(gnt_vld), 0);
    chk("reset_id", int'(gnt_id), 0);
    chk("reset_start", int'(rsc_start), 0);
    chk("reset_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Rotation with done in the second busy cycle
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step(1, 4'hF, m_busy && m_cnt >= 1, 0);
      if (rsc_start) begin
        chk("rotation_order", int'(gnt_id), ord[n]);
        n++;
      end
    end
    chk("rotation_count", n, 5);
    finish_op();

    // Move ptr to 3, then wrap/skip with 4'b0101
    step(1, 4'b0100, 0, 0);
    chk("ptr_setup_grant", int'(gnt_id), 2);
    finish_op();
    step(1, 4'b0101, 0, 0);
    chk("wrap_grant", int'(gnt_id), 0);
    chk("wrap_start", int'(rsc_start), 1);
    finish_op();
    step(1, 4'b0101, 0, 0);
    chk("skip_grant", int'(gnt_id), 2);
    finish_op();

    // Timeout on requester 1
    step(1, 4'b0010, 0, 0);
    chk("timeout_grant", int'(gnt_id), 1);
    hold = 1;
    for (int c = 0; c < 40; c++) begin
      step(1, 4'd0, 0, 0);
      if (gnt_vld) hold++;
      else break;
    end
    chk("timeout_hold_cycles", hold, HOLD + 1);
    chk("timeout_err_set", int'(timeout_err), 1);
    repeat (3) step(0, 4'd0, 0, 0);
    chk("timeout_err_sticky", int'(timeout_err), 1);
    step(1, 4'hF, 0, 0);
    chk("ptr_after_timeout", int'(gnt_id), 2);
    step(1, 4'hF, 0, 0);

    // Asynchronous reset mid-busy
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_vld", int'(gnt_vld), 0);
    chk("async_rst_err", int'(timeout_err), 0);
    exp_q.delete();
    gq.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 4'hF, 0, 0);
    chk("post_reset_grant", int'(gnt_id), 0);

    // Done exactly on the HOLD_MAX cycle
    for (int c = 0; c < 40 && m_busy; c++) step(1, 4'd0, m_busy && m_cnt == HOLD, 0);
    chk("done_on_hold_max_err", int'(timeout_err), 0);

    // Enable low during busy with requests pending
    step(1, 4'b1000, 0, 0);
    chk("en_test_grant", int'(gnt_id), 3);
    step(0, 4'hF, 0, 0);
    step(0, 4'hF, 1, 0);
    repeat (4) step(0, 4'hF, 0, 0);
    chk("enable_off_no_grant", int'(gnt_vld), 0);
    step(1, 4'hF, 0, 0);
    chk("enable_on_grant_vld", int'(gnt_vld), 1);
    chk("enable_on_grant_id", int'(gnt_id), 0);
    finish_op();

    // Timeout with err_clr held: set wins, then clear
    step(1, 4'b0010, 0, 1);
    for (int c = 0; c < 40 && m_busy; c++) step(0, 4'd0, 0, 1);
    chk("set_wins_over_clr", int'(timeout_err), 1);
    step(0, 4'd0, 0, 1);
    chk("err_clr", int'(timeout_err), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 7) != 0, 4'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0);
    end
    finish_op();
    repeat (3) step(0, 4'd0, 0, 0);
    @(negedge clk);
    #1;
    chk("grant_queue_drained", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
